// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline-stage definitions: occupancy state encoding used by the
// elastic stage and by the hazard unit (encoding equals entries held).
package riscv_pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } pipe_state_e;

endpackage

// File: rtl/riscv_pipe_reg.sv
// Payload register with synchronous clear and load enable; clear wins over load.
module riscv_pipe_reg
   import riscv_pipe_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] data_d;
   logic [WIDTH-1:0] data_q;

   // next payload: clear, load or hold
   always_comb begin
      data_d = data_q;
      if (clr) begin
         data_d = '0;
      end else if (en) begin
         data_d = d;
      end
   end

   // payload storage, zeroed by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign q = data_q;

endmodule

// File: rtl/riscv_elastic_stage.sv
// Valid/ready pipeline stage: main payload register plus optional skid entry,
// synchronous flush for branch redirect / exception squash.
module riscv_elastic_stage
   import riscv_pipe_pkg::*;
#(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned SKID     = 1,
   parameter int unsigned CLR_DATA = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       count
);

   localparam logic CLR_EN = (CLR_DATA != 0);

   pipe_state_e      state_d, state_q;
   logic             valid_d, valid_q;
   logic             in_fire, out_fire;
   logic             main_en, main_clr, main_from_skid;
   logic             skid_en, skid_clr;
   logic [WIDTH-1:0] main_din;
   logic [WIDTH-1:0] skid_q;

   // with a skid entry in_ready depends only on flops; without it, it looks through to out_ready
   if (SKID != 0) begin : g_rdy_skid
      assign in_ready = ~rst & (state_q != ST_TWO);
   end else begin : g_rdy_noskid
      assign in_ready = ~rst & (out_ready | ~valid_q);
   end

   assign in_fire   = in_valid & in_ready;
   assign out_fire  = valid_q & out_ready;
   assign out_valid = valid_q;
   assign count     = state_q;

   // occupancy transitions and payload load/clear strobes; flush outranks handshakes
   always_comb begin
      state_d        = state_q;
      main_en        = 1'b0;
      main_clr       = 1'b0;
      main_from_skid = 1'b0;
      skid_en        = 1'b0;
      skid_clr       = 1'b0;
      if (flush) begin
         state_d  = ST_EMPTY;
         main_clr = CLR_EN;
         skid_clr = CLR_EN;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_fire) begin
                  state_d = ST_ONE;
                  main_en = 1'b1;
               end
            end
            ST_ONE: begin
               if (in_fire && out_fire) begin
                  main_en = 1'b1;
               end else if (in_fire && (SKID != 0)) begin
                  state_d = ST_TWO;
                  skid_en = 1'b1;
               end else if (out_fire) begin
                  state_d  = ST_EMPTY;
                  main_clr = CLR_EN;
               end
            end
            ST_TWO: begin
               if (out_fire) begin
                  state_d        = ST_ONE;
                  main_en        = 1'b1;
                  main_from_skid = 1'b1;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
      valid_d  = (state_d != ST_EMPTY);
      main_din = main_from_skid ? skid_q : in_data;
   end

   // control FSM: state doubles as count, out_valid registered alongside
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
      end
   end

   riscv_pipe_reg #(.WIDTH(WIDTH)) u_main_reg (
      .clk (clk),
      .rst (rst),
      .clr (main_clr),
      .en  (main_en),
      .d   (main_din),
      .q   (out_data)
   );

   if (SKID != 0) begin : g_skid
      riscv_pipe_reg #(.WIDTH(WIDTH)) u_skid_reg (
         .clk (clk),
         .rst (rst),
         .clr (skid_clr),
         .en  (skid_en),
         .d   (in_data),
         .q   (skid_q)
      );
   end else begin : g_no_skid
      assign skid_q = '0;
   end

endmodule

// File: tb/tb_riscv_elastic_stage.sv
// Directed and random checks of riscv_elastic_stage in SKID=1 and SKID=0 builds.
module tb_riscv_elastic_stage;

   logic       clk = 1'b0;
   logic       rst = 1'b0;

   logic       fl1 = 1'b0, iv1 = 1'b0, or1 = 1'b0;
   logic [7:0] id1 = '0;
   logic       ir1, ov1;
   logic [7:0] od1;
   logic [1:0] cnt1;

   logic       fl0 = 1'b0, iv0 = 1'b0, or0 = 1'b0;
   logic [7:0] id0 = '0;
   logic       ir0, ov0;
   logic [7:0] od0;
   logic [1:0] cnt0;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   logic [7:0] sv [3] = '{8'h11, 8'h22, 8'h33};
   logic [7:0] q1 [$];
   logic [7:0] q0 [$];

   always #5 clk = ~clk;

   riscv_elastic_stage #(.WIDTH(8), .SKID(1), .CLR_DATA(1)) u_dut_s1 (
      .clk (clk), .rst (rst), .flush (fl1),
      .in_valid (iv1), .in_ready (ir1), .in_data (id1),
      .out_valid (ov1), .out_ready (or1), .out_data (od1), .count (cnt1)
   );

   riscv_elastic_stage #(.WIDTH(8), .SKID(0), .CLR_DATA(1)) u_dut_s0 (
      .clk (clk), .rst (rst), .flush (fl0),
      .in_valid (iv0), .in_ready (ir0), .in_data (id0),
      .out_valid (ov0), .out_ready (or0), .out_data (od0), .count (cnt0)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   initial begin
      logic       v, r, f;
      logic [7:0] d;
      logic       inf, outf;

      // reset asserted asynchronously
      #1 rst = 1'b1;
      #2;
      chk("rst_valid1", ov1, 0);
      chk("rst_data1",  od1, 0);
      chk("rst_count1", cnt1, 0);
      chk("rst_ready1", ir1, 0);
      chk("rst_ready0", ir0, 0);
      @(negedge clk); rst = 1'b0;
      #1;
      chk("rel_ready1", ir1, 1);
      chk("rel_ready0", ir0, 1);

      // async reset mid-transfer drops the held beat without a clock edge
      iv1 = 1'b1; id1 = 8'h5A; or1 = 1'b0;
      @(negedge clk); iv1 = 1'b0;
      chk("mid_valid", ov1, 1);
      chk("mid_data",  od1, 8'h5A);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_valid", ov1, 0);
      chk("mid_rst_data",  od1, 0);
      chk("mid_rst_count", cnt1, 0);
      chk("mid_rst_ready", ir1, 0);
      @(negedge clk); rst = 1'b0;
      #1 chk("mid_rel_ready", ir1, 1);

      // back-to-back stream, one-cycle latency, no bubbles
      or1 = 1'b1; iv1 = 1'b1; id1 = sv[0];
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("stream_valid", ov1, 1);
         chk("stream_data",  od1, sv[k]);
         chk("stream_ready", ir1, 1);
         if (k < 2) id1 = sv[k+1];
         else       iv1 = 1'b0;
      end
      @(negedge clk);
      chk("stream_drain_valid", ov1, 0);
      chk("stream_drain_count", cnt1, 0);
      chk("stream_drain_data",  od1, 0);

      // backpressure fills the skid entry, data held stable
      or1 = 1'b0; iv1 = 1'b1; id1 = 8'hA1;
      @(negedge clk);
      chk("bp_count1", cnt1, 1);
      chk("bp_data1",  od1, 8'hA1);
      chk("bp_ready1", ir1, 1);
      id1 = 8'hA2;
      @(negedge clk);
      chk("bp_count2", cnt1, 2);
      chk("bp_ready2", ir1, 0);
      chk("bp_data2",  od1, 8'hA1);
      iv1 = 1'b0;
      @(negedge clk);
      chk("bp_stable", od1, 8'hA1);
      chk("bp_count_hold", cnt1, 2);
      or1 = 1'b1;
      @(negedge clk);
      chk("bp_second", od1, 8'hA2);
      chk("bp_count_dn1", cnt1, 1);
      @(negedge clk);
      chk("bp_count_dn0", cnt1, 0);
      chk("bp_empty", ov1, 0);

      // flush with two held beats and an offered beat
      or1 = 1'b0; iv1 = 1'b1; id1 = 8'hB1;
      @(negedge clk); id1 = 8'hB2;
      @(negedge clk);
      chk("fl_count2", cnt1, 2);
      fl1 = 1'b1; id1 = 8'hB3;
      @(negedge clk);
      fl1 = 1'b0; iv1 = 1'b0;
      chk("fl_valid", ov1, 0);
      chk("fl_count", cnt1, 0);
      chk("fl_data",  od1, 0);
      or1 = 1'b1;
      @(negedge clk);
      chk("fl_no_b3_valid", ov1, 0);
      chk("fl_no_b3_data",  od1, 0);

      // flush drops the beat accepted in the flush cycle
      iv1 = 1'b1; id1 = 8'hB4;
      @(negedge clk);
      chk("fl2_data", od1, 8'hB4);
      fl1 = 1'b1; id1 = 8'hB5;
      @(negedge clk);
      fl1 = 1'b0; iv1 = 1'b0;
      chk("fl2_valid", ov1, 0);
      chk("fl2_count", cnt1, 0);
      @(negedge clk);
      chk("fl2_no_b5", ov1, 0);

      // single-entry build: combinational ready from out_ready
      or0 = 1'b0; iv0 = 1'b1; id0 = 8'hC4;
      @(negedge clk);
      chk("s0_valid", ov0, 1);
      chk("s0_data",  od0, 8'hC4);
      chk("s0_ready_blocked", ir0, 0);
      or0 = 1'b1; id0 = 8'hC5;
      #1 chk("s0_ready_through", ir0, 1);
      @(negedge clk);
      iv0 = 1'b0;
      chk("s0_next_data",  od0, 8'hC5);
      chk("s0_next_valid", ov0, 1);
      chk("s0_next_count", cnt0, 1);
      @(negedge clk);
      chk("s0_empty_valid", ov0, 0);
      chk("s0_empty_count", cnt0, 0);
      chk("s0_empty_data",  od0, 0);

      // random valid/ready/flush against a FIFO scoreboard per build
      for (int i = 0; i < 10000; i++) begin
         @(negedge clk);
         v = ($urandom_range(0, 9) < 7);
         r = ($urandom_range(0, 9) < 6);
         f = ($urandom_range(0, 31) == 0);
         d = 8'($urandom);
         iv1 = v; or1 = r; fl1 = f; id1 = d;
         iv0 = v; or0 = r; fl0 = f; id0 = d;
         #1;
         chk("rnd1_count", cnt1, q1.size());
         chk("rnd1_valid", ov1, q1.size() != 0);
         chk("rnd1_ready", ir1, q1.size() != 2);
         if (q1.size() != 0) chk("rnd1_data", od1, q1[0]);
         else                chk("rnd1_clr",  od1, 0);
         inf  = v && (q1.size() != 2);
         outf = r && (q1.size() != 0);
         if (outf) void'(q1.pop_front());
         if (inf)  q1.push_back(d);
         if (f)    q1.delete();

         chk("rnd0_count", cnt0, q0.size());
         chk("rnd0_valid", ov0, q0.size() != 0);
         chk("rnd0_ready", ir0, r || (q0.size() == 0));
         if (q0.size() != 0) chk("rnd0_data", od0, q0[0]);
         else                chk("rnd0_clr",  od0, 0);
         inf  = v && (r || (q0.size() == 0));
         outf = r && (q0.size() != 0);
         if (outf) void'(q0.pop_front());
         if (inf)  q0.push_back(d);
         if (f)    q0.delete();
      end
      @(negedge clk);
      iv1 = 1'b0; iv0 = 1'b0; fl1 = 1'b0; fl0 = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
